step_expander: RTL and testbench
================================

Name: step_expander

Overview:
- Splits two-move-format steps, one per axis, into a sequence of one-move-format face turns.
- Two-move format, 6 bits: [5:4] axis; [3:2] turn amount for the axis face with select bit 1; [1:0] turn amount for the face with select bit 0. Amount 2'b00 means no turn.
- One-move format, 5 bits: [4:3] axis, [2] face select, [1:0] amount.
- Sits between the solver step stream and the move executor.
- Buffers incoming steps in a small FIFO and emits moves over a valid/ready handshake.

Parameters:
- DEPTH, 4, input FIFO entries. Power of two, at least 2.
- CNT_W, 16, width of move_count.

Ports:
- clk  input  1  system clock; all logic on the rising edge
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous flush
- step_in  input  6  two-move-format step
- step_valid  input  1  step_in is valid
- step_ready  output  1  FIFO can accept a step
- move_out  output  5  one-move-format move
- move_valid  output  1  move_out is valid
- move_ready  input  1  downstream accepts move_out
- move_count  output  CNT_W  number of moves accepted downstream
- busy  output  1  FIFO non-empty or FSM not in IDLE

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO is emptied; FSM goes to IDLE.
  - move_out=0, move_valid=0, move_count=0.
  - step_ready=1 once rst_n is high (step_ready = !full).
- clear (synchronous):
  - Same effect as reset on the next edge; has priority over every other event.
  - An in-flight move is dropped even if move_ready is high that cycle, and is not counted.
  - A step offered while clear is high is not stored.
- FIFO:
  - Push when step_valid & step_ready.
  - The pop is performed only by the FSM in IDLE.
  - Push and pop in the same cycle are allowed when not full.
  - No push while full, even if a pop occurs that cycle; step_ready is combinational from the occupancy count only.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, HALF0, HALF1. A step register holds the popped step.
- IDLE, FIFO non-empty: pop the head into the step register, then:
  - if amt0=[1:0]!=0: move_out={axis,1'b0,amt0}, move_valid=1, go to HALF0;
  - else if amt1=[3:2]!=0: move_out={axis,1'b1,amt1}, move_valid=1, go to HALF1;
  - else (null step): discard it, stay in IDLE, move_valid stays 0. One cycle is consumed.
- HALF0, on move_valid & move_ready:
  - if amt1!=0: move_out={axis,1'b1,amt1}, move_valid stays 1, go to HALF1;
  - else: move_valid=0, go to IDLE.
- HALF1, on move_valid & move_ready: move_valid=0, go to IDLE.
- Face order is always face0 before face1. Opposite faces commute, so the order is free and this one is fixed.
- While move_valid=1 and move_ready=0, move_out is held stable.
- Latency: a step accepted at edge E into an empty FIFO with the FSM in IDLE gives move_valid high after edge E+1.
- Throughput: one idle cycle (move_valid=0) between the last move of a step and the first move of the next. There is no bypass path.
- Axis 2'b11 is passed through unchecked.
- move_count:
  - Increments by 1 on each move_valid & move_ready.
  - Wraps modulo 2^CNT_W.
  - Null steps do not count.
- Total buffering is DEPTH steps in the FIFO plus one in the step register.

Test Plan:
- Reset, then step_in=6'b01_10_11 with move_ready=1:
  - move_out=5'b01_0_11, then 5'b01_1_10 on consecutive cycles;
  - move_count=2; busy falls one cycle after the second handshake.
- Single-sided steps 6'b00_00_01 then 6'b10_11_00:
  - exactly two moves, 5'b00_0_01 and 5'b10_1_11;
  - one bubble cycle between them; move_count=2.
- Null step 6'b01_00_00 followed by 6'b11_01_01:
  - no move for the null step;
  - then 5'b11_0_01, 5'b11_1_01; move_count=2.
- Backpressure: move_ready=0, step_valid=1 for 8 cycles with distinct steps:
  - exactly DEPTH+1=5 accepted, then step_ready=0;
  - move_out stays stable;
  - after releasing move_ready, all moves emerge in order; no loss or duplication.
- Reset mid-operation:
  - assert rst_n=0 while in HALF0 with 3 steps queued;
  - move_valid drops immediately, move_count=0, step_ready=1;
  - no stale moves after release.
- clear with move_ready=1 on the same cycle as a pending handshake:
  - move not counted; FIFO empty next cycle; the step offered that cycle is not stored.

Source files
------------

// File: rtl/step_expander.sv
// Expands two-move-format steps (both faces of one axis) into single-face moves.
// Steps are buffered in a small FIFO; moves leave over a valid/ready handshake.
module step_expander #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [5:0]       step_in,
    input  logic             step_valid,
    output logic             step_ready,
    output logic [4:0]       move_out,
    output logic             move_valid,
    input  logic             move_ready,
    output logic [CNT_W-1:0] move_count,
    output logic             busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HALF0 = 2'd1,
        HALF1 = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [5:0]       fifo_mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      level_reg;
    logic [5:0]       step_reg;
    logic [CNT_W-1:0] count_reg;
    logic [5:0]       head;
    logic             push;
    logic             pop;
    logic             fire;

    assign head       = fifo_mem[rd_ptr_reg];
    // Readiness depends on occupancy only, so a same-cycle pop never frees a full slot.
    assign step_ready = (level_reg != FULL_LEVEL);
    assign push       = step_valid && step_ready && !clear;
    assign pop        = (state_reg == IDLE) && (level_reg != '0) && !clear;
    assign fire       = move_valid && move_ready;
    assign busy       = (level_reg != '0) || (state_reg != IDLE);
    assign move_count = count_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= step_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            level_reg <= level_reg + (AW+1)'(push) - (AW+1)'(pop);
            if (fire) begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end
    end

    // State register; the popped step is latched alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            step_reg  <= '0;
        end else if (clear) begin
            state_reg <= IDLE;
            step_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (pop) begin
                step_reg <= head;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (pop) begin
                    if (head[1:0] != 2'b00) begin
                        state_next = HALF0;
                    end else if (head[3:2] != 2'b00) begin
                        state_next = HALF1;
                    end
                end
            end
            HALF0: begin
                if (fire) begin
                    state_next = (step_reg[3:2] != 2'b00) ? HALF1 : IDLE;
                end
            end
            HALF1: begin
                if (fire) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Moves are decoded from the held step, so move_out is stable under backpressure.
    always_comb begin
        move_valid = 1'b0;
        move_out   = '0;
        case (state_reg)
            HALF0: begin
                move_valid = 1'b1;
                move_out   = {step_reg[5:4], 1'b0, step_reg[1:0]};
            end
            HALF1: begin
                move_valid = 1'b1;
                move_out   = {step_reg[5:4], 1'b1, step_reg[3:2]};
            end
            default: begin
                move_valid = 1'b0;
                move_out   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_step_expander.sv
// Bench for step_expander: vector table plus scoreboard of expected moves,
// with hand-written sequences for backpressure, clear and mid-operation reset.
module tb_step_expander;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear = 1'b0;
    logic [5:0]       step_in = '0;
    logic             step_valid = 1'b0;
    logic             step_ready;
    logic [4:0]       move_out;
    logic             move_valid;
    logic             move_ready = 1'b0;
    logic [CNT_W-1:0] move_count;
    logic             busy;

    int               n_checks = 0;
    int               n_fail = 0;
    int               cyc = 0;
    int               last_busy = 0;
    int               n_moves = 0;
    logic [4:0]       exp_q[$];
    logic [4:0]       obs_q[$];
    int               obs_t[$];
    logic [CNT_W-1:0] exp_cnt = '0;
    logic             hold_prev = 1'b0;
    logic [4:0]       prev_out = '0;

    typedef struct {
        logic [5:0] step;
        int         n;
        logic [4:0] m0;
        logic [4:0] m1;
    } vec_t;
    vec_t vec [6];

    always #5 clk = ~clk;

    step_expander #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .step_in    (step_in),
        .step_valid (step_valid),
        .step_ready (step_ready),
        .move_out   (move_out),
        .move_valid (move_valid),
        .move_ready (move_ready),
        .move_count (move_count),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] obs_at(input int k);
        return (obs_q.size() > k) ? 32'(obs_q[k]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] gap_at(input int k);
        return (obs_t.size() > k) ? 32'(obs_t[k] - obs_t[k-1]) : 32'hFFFF_FFFF;
    endfunction

    function automatic void expect_step(input logic [5:0] s);
        if (s[1:0] != 2'b00) exp_q.push_back({s[5:4], 1'b0, s[1:0]});
        if (s[3:2] != 2'b00) exp_q.push_back({s[5:4], 1'b1, s[3:2]});
    endfunction

    // Observes both handshakes on the falling edge, i.e. just before the edge that commits them.
    task automatic monitor();
        logic [4:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (busy) last_busy = cyc;
            if (!rst_n) begin
                exp_q.delete();
                exp_cnt = '0;
                hold_prev = 1'b0;
            end else begin
                check("move_count", move_count, exp_cnt);
                if (hold_prev) begin
                    check("hold_valid", move_valid, 1);
                    check("hold_out", move_out, prev_out);
                end
                if (clear) begin
                    exp_q.delete();
                    exp_cnt = '0;
                    hold_prev = 1'b0;
                end else begin
                    if (move_valid && move_ready) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_move", exp_q.size(), 1);
                        end else begin
                            e = exp_q.pop_front();
                            check("move_out", move_out, e);
                        end
                        obs_q.push_back(move_out);
                        obs_t.push_back(cyc);
                        exp_cnt++;
                        n_moves++;
                        $display("move %b at cycle %0d, count %0d", move_out, cyc, move_count);
                    end
                    if (step_valid && step_ready) expect_step(step_in);
                    hold_prev = move_valid && !move_ready;
                    prev_out = move_out;
                end
            end
        end
    endtask

    task automatic send(input logic [5:0] s);
        int t = 0;
        step_in = s;
        step_valid = 1'b1;
        @(negedge clk);
        while (!step_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("send_accept", step_ready, 1);
        @(posedge clk);
        #1;
        step_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("idle_reached", busy, 0);
        check("sb_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [CNT_W-1:0] c0;
        int               m0;
        int               acc;
        logic [2:0]       ib;

        vec[0] = '{6'b01_10_11, 2, 5'b01_0_11, 5'b01_1_10};
        vec[1] = '{6'b00_00_01, 1, 5'b00_0_01, 5'b00000};
        vec[2] = '{6'b10_11_00, 1, 5'b10_1_11, 5'b00000};
        vec[3] = '{6'b01_00_00, 0, 5'b00000, 5'b00000};
        vec[4] = '{6'b11_01_01, 2, 5'b11_0_01, 5'b11_1_01};
        vec[5] = '{6'b11_11_10, 2, 5'b11_0_10, 5'b11_1_11};

        fork
            monitor();
        join_none

        #12;
        check("rst_move_valid", move_valid, 0);
        check("rst_move_out", move_out, 0);
        check("rst_move_count", move_count, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_step_ready", step_ready, 1);

        // Both faces on consecutive cycles, busy falls right after the second move.
        move_ready = 1'b1;
        obs_q.delete(); obs_t.delete();
        send(6'b01_10_11);
        wait_idle();
        check("two_face_m0", obs_at(0), 5'b01_0_11);
        check("two_face_m1", obs_at(1), 5'b01_1_10);
        check("two_face_gap", gap_at(1), 1);
        check("busy_fall", last_busy, (obs_t.size() > 1) ? obs_t[1] : -1);
        check("two_face_count", move_count, 2);
        $display("seq two-face: %0d moves", obs_q.size());

        // Back-to-back single-sided steps leave one bubble between their moves.
        obs_q.delete(); obs_t.delete();
        c0 = move_count;
        send(6'b00_00_01);
        send(6'b10_11_00);
        wait_idle();
        check("single_n", obs_q.size(), 2);
        check("single_m0", obs_at(0), 5'b00_0_01);
        check("single_m1", obs_at(1), 5'b10_1_11);
        check("single_gap", gap_at(1), 2);
        check("single_count", move_count - c0, 2);
        $display("seq single-sided: %0d moves", obs_q.size());

        // Null step is swallowed.
        obs_q.delete(); obs_t.delete();
        c0 = move_count;
        send(6'b01_00_00);
        send(6'b11_01_01);
        wait_idle();
        check("null_n", obs_q.size(), 2);
        check("null_m0", obs_at(0), 5'b11_0_01);
        check("null_m1", obs_at(1), 5'b11_1_01);
        check("null_count", move_count - c0, 2);
        $display("seq null-step: %0d moves", obs_q.size());

        for (int i = 0; i < 6; i++) begin
            obs_q.delete(); obs_t.delete();
            c0 = move_count;
            send(vec[i].step);
            wait_idle();
            check("vec_n", obs_q.size(), vec[i].n);
            for (int k = 0; k < vec[i].n; k++) begin
                check("vec_move", obs_at(k), (k == 0) ? vec[i].m0 : vec[i].m1);
            end
            check("vec_count", move_count - c0, vec[i].n);
            $display("vec %0d step=%b moves=%0d", i, vec[i].step, obs_q.size());
        end

        // Backpressure: DEPTH in the FIFO plus one in the step register.
        move_ready = 1'b0;
        acc = 0;
        m0 = n_moves;
        for (int i = 0; i < 8; i++) begin
            ib = 3'(i);
            step_in = {ib[1:0], 1'b1, ib[2], 2'b10};
            step_valid = 1'b1;
            @(negedge clk);
            if (step_ready) acc++;
            @(posedge clk);
            #1;
        end
        step_valid = 1'b0;
        check("bp_accepted", acc, DEPTH + 1);
        check("bp_step_ready", step_ready, 0);
        check("bp_no_moves", n_moves - m0, 0);
        move_ready = 1'b1;
        wait_idle();
        check("bp_moves", n_moves - m0, 2 * (DEPTH + 1));
        $display("seq backpressure: accepted %0d, moves %0d", acc, n_moves - m0);

        // clear during a pending handshake drops the move and the offered step.
        send(6'b10_01_10);
        wait_idle();
        move_ready = 1'b0;
        send(6'b00_11_01);
        repeat (2) @(posedge clk);
        #1;
        check("pre_clear_valid", move_valid, 1);
        clear = 1'b1;
        move_ready = 1'b1;
        step_in = 6'b01_01_01;
        step_valid = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        step_valid = 1'b0;
        check("clear_count", move_count, 0);
        check("clear_valid", move_valid, 0);
        check("clear_busy", busy, 0);
        check("clear_ready", step_ready, 1);
        m0 = n_moves;
        repeat (6) @(posedge clk);
        #1;
        check("clear_no_moves", n_moves - m0, 0);
        $display("seq clear: moves after clear %0d", n_moves - m0);

        // Asynchronous reset while in HALF0 with three steps queued.
        move_ready = 1'b0;
        send(6'b01_01_10);
        send(6'b10_10_01);
        send(6'b11_00_11);
        send(6'b00_01_01);
        @(posedge clk);
        #1;
        check("pre_rst_valid", move_valid, 1);
        check("pre_rst_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", move_valid, 0);
        check("arst_count", move_count, 0);
        check("arst_ready", step_ready, 1);
        check("arst_busy", busy, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        move_ready = 1'b1;
        m0 = n_moves;
        repeat (10) @(posedge clk);
        #1;
        check("arst_no_stale", n_moves - m0, 0);
        $display("seq reset: moves after reset %0d", n_moves - m0);

        obs_q.delete(); obs_t.delete();
        send(6'b10_11_01);
        wait_idle();
        check("post_rst_m0", obs_at(0), 5'b10_0_01);
        check("post_rst_m1", obs_at(1), 5'b10_1_11);
        check("post_rst_count", move_count, 2);
        $display("seq post-reset: %0d moves", obs_q.size());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
